// File: rtl/seq_chunk_comparator_if.sv
// Request/result bundle of the chunked sequential comparator: operands and mode
// in, start/busy/done handshake and the registered comparison flags out.
interface seq_chunk_comparator_if #(
  parameter int WIDTH = 24
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic             s;
  logic             eq;
  logic             lt;
  logic             gt;

  modport master (
    output start, a, b, mode,
    input  busy, done, s, eq, lt, gt
  );

  modport slave (
    input  start, a, b, mode,
    output busy, done, s, eq, lt, gt
  );
endinterface

// File: rtl/seq_chunk_comparator.sv
// Multi-mode comparator that walks two WIDTH-bit operands CHUNK bits per clock,
// most-significant chunk first, stopping at the first chunk that differs.
module seq_chunk_comparator #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_chunk_comparator_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    M_EQ  = 2'b00,
    M_NE  = 2'b01,
    M_LTU = 2'b10,
    M_LTS = 2'b11
  } mode_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  mode_t            mode_q, mode_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             s_q, s_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] ca, cb;
  logic             signed_top;

  // Flipping the sign bit of the top chunk maps two's-complement order onto unsigned order.
  assign signed_top = (mode_q == M_LTS) && (idx_q == LAST_IDX);
  assign ca = a_q[int'(idx_q)*CHUNK +: CHUNK] ^ (signed_top ? MSB_MASK : '0);
  assign cb = b_q[int'(idx_q)*CHUNK +: CHUNK] ^ (signed_top ? MSB_MASK : '0);

  always_comb begin
    // NOTE: every next-state value gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    s_d     = s_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = mode_t'(bus.mode);
          idx_d   = LAST_IDX;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (ca != cb) begin
          eq_d    = 1'b0;
          lt_d    = (ca < cb);
          gt_d    = (ca > cb);
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end

        if (done_d) begin
          unique case (mode_q)
            M_EQ:    s_d = eq_d;
            M_NE:    s_d = !eq_d;
            default: s_d = lt_d;
          endcase
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: operand registers are ordinary flops, so they take the async clear along with the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= M_EQ;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      s_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.eq   = eq_q;
  assign bus.lt   = lt_q;
  assign bus.gt   = gt_q;

endmodule
